// File: rtl/id_arb_pkg.sv
// Shared types and helpers for the ID allocate/free arbiter.
package id_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    typedef enum logic {
        OP_ALLOC = 1'b0,
        OP_FREE  = 1'b1
    } op_e;

    localparam int unsigned PERF_CNT_W = 16;

    // Index width that stays at least one bit for single-entry classes.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: lowest requesting index at or after the pointer wins.
// The pointer moves past adv_idx only when the caller reports completion via adv.
module rr_arbiter
    import id_arb_pkg::*;
#(
    parameter  int unsigned N  = 2,
    localparam int unsigned IW = idx_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          adv,
    input  logic [IW-1:0] adv_idx,
    output logic [N-1:0]  gnt_onehot,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    logic [IW-1:0] r_ptr;
    logic          w_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (adv) begin
            r_ptr <= (adv_idx == IW'(N - 1)) ? '0 : adv_idx + 1'b1;
        end
    end

    // First pass covers indices at/after the pointer, second pass wraps around.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        w_hit      = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!w_hit && req[i] && (IW'(i) >= r_ptr)) begin
                w_hit         = 1'b1;
                gnt_onehot[i] = 1'b1;
                gnt_idx       = IW'(i);
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!w_hit && req[i]) begin
                w_hit         = 1'b1;
                gnt_onehot[i] = 1'b1;
                gnt_idx       = IW'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/id_alloc_free_arbiter.sv
// Shares one ID allocate/restore unit between alloc and free requesters, one op per 3 cycles.
// Define ID_ARB_PERF_CNT_EN to add saturating alloc/free/deny performance counters.
module id_alloc_free_arbiter
    import id_arb_pkg::*;
#(
    parameter int unsigned ID_WIDTH       = 4,
    parameter int unsigned NUM_ALLOC      = 2,
    parameter int unsigned NUM_FREE       = 2,
    parameter int unsigned MAX_FREE_BURST = 4,
    parameter int unsigned DENY_HOLDOFF   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_ALLOC-1:0]          alloc_valid,
    input  logic [NUM_ALLOC*ID_WIDTH-1:0] alloc_orig_id,
    output logic [NUM_ALLOC-1:0]          alloc_done,
    output logic [ID_WIDTH-1:0]           alloc_unique_id,
    input  logic [NUM_FREE-1:0]           free_valid,
    input  logic [NUM_FREE*ID_WIDTH-1:0]  free_unique_id,
    output logic [NUM_FREE-1:0]           free_done,
    output logic [ID_WIDTH-1:0]           free_restored_id,
    output logic                          au_alloc_req,
    output logic [ID_WIDTH-1:0]           au_in_orig_id,
    input  logic                          au_alloc_gnt,
    input  logic [ID_WIDTH-1:0]           au_unique_id,
    input  logic                          au_id_matrix_full,
    output logic                          au_free_req,
    output logic [ID_WIDTH-1:0]           au_unique_id_to_free,
    input  logic [ID_WIDTH-1:0]           au_restored_id,
    output logic                          busy
`ifdef ID_ARB_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0]         perf_alloc_cnt,
    output logic [PERF_CNT_W-1:0]         perf_free_cnt,
    output logic [PERF_CNT_W-1:0]         perf_deny_cnt
`endif
);

    localparam int unsigned AIW = idx_w(NUM_ALLOC);
    localparam int unsigned FIW = idx_w(NUM_FREE);
    localparam int unsigned IW  = (AIW > FIW) ? AIW : FIW;
    localparam int unsigned BW  = idx_w(MAX_FREE_BURST + 1);
    localparam int unsigned HW  = idx_w(DENY_HOLDOFF + 1);

    state_e              r_state;
    op_e                 r_op;
    logic [IW-1:0]       r_idx;
    logic [ID_WIDTH-1:0] r_id;
    logic [ID_WIDTH-1:0] r_res;
    logic [BW-1:0]       r_burst;
    logic [HW-1:0]       r_holdoff;

    logic [NUM_ALLOC-1:0] w_a_onehot;
    logic [AIW-1:0]       w_a_idx;
    logic                 w_a_any;
    logic [NUM_FREE-1:0]  w_f_onehot;
    logic [FIW-1:0]       w_f_idx;
    logic                 w_f_any;
    logic [ID_WIDTH-1:0]  w_a_id;
    logic [ID_WIDTH-1:0]  w_f_id;

    logic w_alloc_elig;
    logic w_pick_alloc;
    logic w_pick_free;
    logic w_issue_a;
    logic w_issue_f;
    logic w_deny;
    logic w_resp_a;
    logic w_resp_f;

    rr_arbiter #(.N(NUM_ALLOC)) u_alloc_rr (
        .clk        (clk),
        .rst        (rst),
        .req        (alloc_valid),
        .adv        (w_resp_a),
        .adv_idx    (r_idx[AIW-1:0]),
        .gnt_onehot (w_a_onehot),
        .gnt_idx    (w_a_idx),
        .any        (w_a_any)
    );

    rr_arbiter #(.N(NUM_FREE)) u_free_rr (
        .clk        (clk),
        .rst        (rst),
        .req        (free_valid),
        .adv        (w_resp_f),
        .adv_idx    (r_idx[FIW-1:0]),
        .gnt_onehot (w_f_onehot),
        .gnt_idx    (w_f_idx),
        .any        (w_f_any)
    );

    always_comb begin
        w_a_id = '0;
        for (int unsigned i = 0; i < NUM_ALLOC; i++) begin
            if (w_a_onehot[i]) w_a_id = alloc_orig_id[i*ID_WIDTH +: ID_WIDTH];
        end
    end

    always_comb begin
        w_f_id = '0;
        for (int unsigned i = 0; i < NUM_FREE; i++) begin
            if (w_f_onehot[i]) w_f_id = free_unique_id[i*ID_WIDTH +: ID_WIDTH];
        end
    end

    // Free normally wins; a starved alloc wins once the free burst budget is spent.
    assign w_alloc_elig = w_a_any && !au_id_matrix_full && (r_holdoff == '0);
    assign w_pick_alloc = (r_state == IDLE) && w_alloc_elig &&
                          (!w_f_any || (r_burst == BW'(MAX_FREE_BURST)));
    assign w_pick_free  = (r_state == IDLE) && w_f_any && !w_pick_alloc;

    assign w_issue_a = (r_state == ISSUE) && (r_op == OP_ALLOC);
    assign w_issue_f = (r_state == ISSUE) && (r_op == OP_FREE);
    assign w_deny    = w_issue_a && !au_alloc_gnt;
    assign w_resp_a  = (r_state == RESP) && (r_op == OP_ALLOC);
    assign w_resp_f  = (r_state == RESP) && (r_op == OP_FREE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_op    <= OP_ALLOC;
            r_idx   <= '0;
            r_id    <= '0;
            r_res   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_alloc) begin
                        r_op    <= OP_ALLOC;
                        r_idx   <= IW'(w_a_idx);
                        r_id    <= w_a_id;
                        r_state <= ISSUE;
                    end else if (w_pick_free) begin
                        r_op    <= OP_FREE;
                        r_idx   <= IW'(w_f_idx);
                        r_id    <= w_f_id;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_deny) begin
                        r_state <= IDLE;
                    end else begin
                        r_res   <= (r_op == OP_ALLOC) ? au_unique_id : au_restored_id;
                        r_state <= RESP;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_burst   <= '0;
            r_holdoff <= '0;
        end else begin
            if (!w_a_any || w_pick_alloc) begin
                r_burst <= '0;
            end else if (w_pick_free && (r_burst != BW'(MAX_FREE_BURST))) begin
                r_burst <= r_burst + 1'b1;
            end

            if (w_deny) begin
                r_holdoff <= HW'(DENY_HOLDOFF);
            end else if (r_holdoff != '0) begin
                r_holdoff <= r_holdoff - 1'b1;
            end
        end
    end

    assign au_alloc_req         = w_issue_a;
    assign au_in_orig_id        = w_issue_a ? r_id : '0;
    assign au_free_req          = w_issue_f;
    assign au_unique_id_to_free = w_issue_f ? r_id : '0;

    always_comb begin
        alloc_done = '0;
        for (int unsigned i = 0; i < NUM_ALLOC; i++) begin
            alloc_done[i] = w_resp_a && (r_idx == IW'(i));
        end
    end

    always_comb begin
        free_done = '0;
        for (int unsigned i = 0; i < NUM_FREE; i++) begin
            free_done[i] = w_resp_f && (r_idx == IW'(i));
        end
    end

    assign alloc_unique_id  = w_resp_a ? r_res : '0;
    assign free_restored_id = w_resp_f ? r_res : '0;
    assign busy             = (r_state != IDLE);

`ifdef ID_ARB_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_alloc_cnt <= '0;
            perf_free_cnt  <= '0;
            perf_deny_cnt  <= '0;
        end else begin
            if (w_resp_a && (perf_alloc_cnt != '1)) perf_alloc_cnt <= perf_alloc_cnt + 1'b1;
            if (w_resp_f && (perf_free_cnt != '1))  perf_free_cnt  <= perf_free_cnt + 1'b1;
            if (w_deny && (perf_deny_cnt != '1))    perf_deny_cnt  <= perf_deny_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_id_alloc_free_arbiter.sv
// Bench for id_alloc_free_arbiter: table of single-shot scenarios plus multi-cycle sequences.
// Allocator model: unique = orig + 2, restored = unique ^ 0xC.
module tb_id_alloc_free_arbiter;

    localparam int unsigned IDW = 4;
    localparam int unsigned NA  = 2;
    localparam int unsigned NF  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NA-1:0]       alloc_valid;
    logic [NA*IDW-1:0]   alloc_orig_id;
    logic [NA-1:0]       alloc_done;
    logic [IDW-1:0]      alloc_unique_id;
    logic [NF-1:0]       free_valid;
    logic [NF*IDW-1:0]   free_unique_id;
    logic [NF-1:0]       free_done;
    logic [IDW-1:0]      free_restored_id;
    logic                au_alloc_req;
    logic [IDW-1:0]      au_in_orig_id;
    logic                au_alloc_gnt;
    logic [IDW-1:0]      au_unique_id;
    logic                au_id_matrix_full;
    logic                au_free_req;
    logic [IDW-1:0]      au_unique_id_to_free;
    logic [IDW-1:0]      au_restored_id;
    logic                busy;
`ifdef ID_ARB_PERF_CNT_EN
    logic [15:0]         perf_alloc_cnt;
    logic [15:0]         perf_free_cnt;
    logic [15:0]         perf_deny_cnt;
`endif

    always #5 clk = ~clk;

    assign au_unique_id   = au_in_orig_id + 4'd2;
    assign au_restored_id = au_unique_id_to_free ^ 4'hC;

    id_alloc_free_arbiter #(
        .ID_WIDTH(4), .NUM_ALLOC(2), .NUM_FREE(2), .MAX_FREE_BURST(4), .DENY_HOLDOFF(2)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .alloc_valid          (alloc_valid),
        .alloc_orig_id        (alloc_orig_id),
        .alloc_done           (alloc_done),
        .alloc_unique_id      (alloc_unique_id),
        .free_valid           (free_valid),
        .free_unique_id       (free_unique_id),
        .free_done            (free_done),
        .free_restored_id     (free_restored_id),
        .au_alloc_req         (au_alloc_req),
        .au_in_orig_id        (au_in_orig_id),
        .au_alloc_gnt         (au_alloc_gnt),
        .au_unique_id         (au_unique_id),
        .au_id_matrix_full    (au_id_matrix_full),
        .au_free_req          (au_free_req),
        .au_unique_id_to_free (au_unique_id_to_free),
        .au_restored_id       (au_restored_id),
        .busy                 (busy)
`ifdef ID_ARB_PERF_CNT_EN
        ,
        .perf_alloc_cnt       (perf_alloc_cnt),
        .perf_free_cnt        (perf_free_cnt),
        .perf_deny_cnt        (perf_deny_cnt)
`endif
    );

    // Event encoding: {is_alloc, requester index, delivered ID}.
    typedef struct {
        logic [1:0]  av;
        logic [7:0]  aid;
        logic [1:0]  fv;
        logic [7:0]  fid;
        int unsigned n;
        logic [5:0]  ev [4];
    } vec_t;

    vec_t       vt [7];
    logic [5:0] sb [$];
    int         n_chk  = 0;
    int         n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_chk++;
        if (act !== req_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req_v, $time);
        end
    endtask

    task automatic do_reset();
        alloc_valid = '0;
        free_valid  = '0;
        rst         = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Serve requesters until every expected event is popped; sticky requesters re-request after done.
    task automatic run(input logic [1:0] sticky_a, input logic [1:0] sticky_f, input int unsigned budget,
                       output int unsigned first_lat, output int unsigned n_areq);
        int unsigned cyc;
        logic [5:0]  got;
        logic [5:0]  want;
        cyc       = 0;
        first_lat = 0;
        n_areq    = 0;
        while (sb.size() > 0 && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
            if (au_alloc_req) n_areq++;
            check("single_au_req", {31'd0, au_alloc_req & au_free_req}, 32'd0);
            if (alloc_done == '0 && free_done == '0) begin
                check("idle_results", {24'd0, alloc_unique_id, free_restored_id}, 32'd0);
            end else begin
                check("done_onehot", $countones({alloc_done, free_done}), 32'd1);
                if (first_lat == 0) first_lat = cyc;
                if (alloc_done != '0) got = {1'b1, alloc_done[1], alloc_unique_id};
                else                  got = {1'b0, free_done[1], free_restored_id};
                want = sb.pop_front();
                check("done_event", {26'd0, got}, {26'd0, want});
                alloc_valid = alloc_valid & ~(alloc_done & ~sticky_a);
                free_valid  = free_valid & ~(free_done & ~sticky_f);
                if (sb.size() == 0) begin
                    alloc_valid = alloc_valid & ~sticky_a;
                    free_valid  = free_valid & ~sticky_f;
                end
            end
        end
        check("events_drained", sb.size(), 32'd0);
        sb.delete();
    endtask

    task automatic quiet(input int unsigned ncyc);
        for (int unsigned i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            check("no_stray_done", {28'd0, alloc_done, free_done}, 32'd0);
            check("no_stray_req", {31'd0, au_alloc_req | au_free_req}, 32'd0);
        end
        check("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned lat;
        int unsigned nreq;
        int unsigned na;
        int unsigned first;
        int unsigned second;
        bit          seen;

        au_alloc_gnt      = 1'b1;
        au_id_matrix_full = 1'b0;
        alloc_orig_id     = '0;
        free_unique_id    = '0;
        alloc_valid       = '0;
        free_valid        = '0;
        rst               = 1'b1;

        vt[0] = '{av:2'b01, aid:8'h03, fv:2'b00, fid:8'h00, n:1, ev:'{6'h25, 6'h00, 6'h00, 6'h00}};
        vt[1] = '{av:2'b11, aid:8'h73, fv:2'b00, fid:8'h00, n:2, ev:'{6'h25, 6'h39, 6'h00, 6'h00}};
        vt[2] = '{av:2'b01, aid:8'h03, fv:2'b01, fid:8'h05, n:2, ev:'{6'h09, 6'h25, 6'h00, 6'h00}};
        vt[3] = '{av:2'b00, aid:8'h00, fv:2'b11, fid:8'h21, n:2, ev:'{6'h0D, 6'h1E, 6'h00, 6'h00}};
        vt[4] = '{av:2'b10, aid:8'hE0, fv:2'b10, fid:8'h60, n:2, ev:'{6'h1A, 6'h30, 6'h00, 6'h00}};
        vt[5] = '{av:2'b10, aid:8'hF0, fv:2'b00, fid:8'h00, n:1, ev:'{6'h31, 6'h00, 6'h00, 6'h00}};
        vt[6] = '{av:2'b11, aid:8'h21, fv:2'b11, fid:8'h43, n:4, ev:'{6'h0F, 6'h18, 6'h23, 6'h34}};

        do_reset();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {28'd0, alloc_done, free_done}, 32'd0);
        check("rst_au_req", {30'd0, au_alloc_req, au_free_req}, 32'd0);
        check("rst_au_ids", {24'd0, au_in_orig_id, au_unique_id_to_free}, 32'd0);
        check("rst_results", {24'd0, alloc_unique_id, free_restored_id}, 32'd0);

        for (int v = 0; v < 7; v++) begin
            do_reset();
            alloc_orig_id  = vt[v].aid;
            free_unique_id = vt[v].fid;
            na = 0;
            for (int k = 0; k < int'(vt[v].n); k++) begin
                sb.push_back(vt[v].ev[k]);
                if (vt[v].ev[k][5]) na++;
            end
            alloc_valid = vt[v].av;
            free_valid  = vt[v].fv;
            run(2'b00, 2'b00, 40, lat, nreq);
            check("first_done_latency", lat, 32'd2);
            check("au_alloc_req_cycles", nreq, na);
            quiet(3);
        end

        // Both alloc requesters held: service alternates and the pointer wraps.
        do_reset();
        alloc_orig_id = 8'h73;
        sb.push_back(6'h25); sb.push_back(6'h39); sb.push_back(6'h25); sb.push_back(6'h39);
        alloc_valid = 2'b11;
        run(2'b11, 2'b00, 40, lat, nreq);
        quiet(3);

        // Continuous frees: the pending alloc gets in after four free grants.
        do_reset();
        alloc_orig_id  = 8'h03;
        free_unique_id = 8'h21;
        sb.push_back(6'h0D); sb.push_back(6'h1E); sb.push_back(6'h0D); sb.push_back(6'h1E);
        sb.push_back(6'h25);
        alloc_valid = 2'b01;
        free_valid  = 2'b11;
        run(2'b00, 2'b11, 60, lat, nreq);
        quiet(3);

        // Denied alloc: no done, and re-issue only after the holdoff.
        do_reset();
        au_alloc_gnt  = 1'b0;
        alloc_orig_id = 8'h03;
        alloc_valid   = 2'b01;
        first  = 0;
        second = 0;
        for (int unsigned c = 1; c <= 14; c++) begin
            @(posedge clk);
            #1;
            check("deny_no_done", {30'd0, alloc_done}, 32'd0);
            if (au_alloc_req) begin
                if (first == 0)       first  = c;
                else if (second == 0) second = c;
            end
        end
        check("deny_first_issue", first, 32'd1);
        check("deny_holdoff_gap", second - first, 32'd4);
        au_alloc_gnt = 1'b1;
        sb.push_back(6'h25);
        run(2'b00, 2'b00, 20, lat, nreq);
        quiet(3);

        // Matrix full masks alloc while free still proceeds.
        do_reset();
        au_id_matrix_full = 1'b1;
        alloc_orig_id     = 8'h03;
        free_unique_id    = 8'h05;
        sb.push_back(6'h09);
        alloc_valid = 2'b01;
        free_valid  = 2'b01;
        run(2'b00, 2'b00, 20, lat, nreq);
        quiet(8);
        au_id_matrix_full = 1'b0;
        sb.push_back(6'h25);
        run(2'b00, 2'b00, 20, lat, nreq);
        quiet(3);

        // Reset during ISSUE drops the op; the held request is served afterwards.
        do_reset();
        alloc_orig_id = 8'h03;
        alloc_valid   = 2'b01;
        seen = 1'b0;
        for (int unsigned c = 0; c < 6 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (au_alloc_req) seen = 1'b1;
        end
        check("issue_reached", {31'd0, seen}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_au_req", {31'd0, au_alloc_req}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_mid_no_done", {30'd0, alloc_done}, 32'd0);
        rst = 1'b0;
        sb.push_back(6'h25);
        run(2'b00, 2'b00, 20, lat, nreq);
        check("rerun_latency", lat, 32'd2);
        quiet(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
